// File: rtl/rp_pio_pkg.sv
// Shared types and constants for the Root Port PIO status logger.
// The status bit index is space*8 + type, so only bits 0..2, 8..10 and 16..18 can ever be set.
package rp_pio_pkg;

  typedef enum logic [1:0] {
    SPACE_CFG = 2'd0,
    SPACE_IO  = 2'd1,
    SPACE_MEM = 2'd2,
    SPACE_ILL = 2'd3
  } pio_space_e;

  typedef enum logic [1:0] {
    ERR_UR  = 2'd0,
    ERR_CA  = 2'd1,
    ERR_CTO = 2'd2,
    ERR_ILL = 2'd3
  } pio_err_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_TRIG = 2'd1,
    ST_HOLD = 2'd2
  } log_state_e;

  localparam logic [31:0] STATUS_VALID = 32'h0007_0707;

  localparam logic [2:0] ADDR_STATUS = 3'd0;
  localparam logic [2:0] ADDR_PTR    = 3'd1;
  localparam logic [2:0] ADDR_HDR0   = 3'd2;
  localparam logic [2:0] ADDR_HDR1   = 3'd3;
  localparam logic [2:0] ADDR_HDR2   = 3'd4;
  localparam logic [2:0] ADDR_HDR3   = 3'd5;

  // space*8 + type, expressed as a bit concatenation (bit 2 is always 0)
  function automatic logic [4:0] status_idx(input logic [1:0] space, input logic [1:0] typ);
    return {space, 1'b0, typ};
  endfunction

endpackage

// File: rtl/rp_pio_hdr_log.sv
// N_DW x 32-bit capture register with a single load strobe and a DW read mux.
// Reusable for any TLP header/prefix log that is captured whole and read per DW.
module rp_pio_hdr_log #(
  parameter int N_DW  = 4,
  parameter int SEL_W = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [N_DW*32-1:0]    hdr_in,
  input  logic [SEL_W-1:0]      dw_sel,
  output logic [31:0]           dw_out
);

  logic [31:0] dw_q [N_DW];
  logic [31:0] dw_d [N_DW];

  generate
    for (genvar gi = 0; gi < N_DW; gi++) begin : g_dw
      always_comb begin
        dw_d[gi] = load ? hdr_in[gi*32 +: 32] : dw_q[gi];
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          dw_q[gi] <= '0;
        end else begin
          dw_q[gi] <= dw_d[gi];
        end
      end
    end
  endgenerate

  assign dw_out = dw_q[dw_sel];

endmodule

// File: rtl/rp_pio_status_logger.sv
// Turns PIO completion failures into RW1C status bits, logs the header of the first
// unmasked error and holds a DPC trigger request until the DPC controller acknowledges it.
module rp_pio_status_logger
  import rp_pio_pkg::*;
#(
  parameter int HDR_DW = 4,
  parameter int ADDR_W = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  err_valid,
  input  logic [1:0]            err_space,
  input  logic [1:0]            err_type,
  input  logic [HDR_DW*32-1:0]  err_hdr,
  input  logic [31:0]           pio_mask,
  input  logic [ADDR_W-1:0]     reg_addr,
  input  logic                  write_enable,
  input  logic [31:0]           write_data,
  output logic [31:0]           read_data,
  output logic                  dpc_trig_req,
  input  logic                  dpc_trig_ack
);

  logic [31:0] status_q, status_d;
  logic [4:0]  ptr_q, ptr_d;
  logic        req_q, req_d;
  log_state_e  state_q, state_d;

  logic        ev_legal;
  logic        ev_unmasked;
  logic [4:0]  ev_idx;
  logic [31:0] set_vec;
  logic [31:0] clr_vec;
  logic        log_load;
  logic [1:0]  hdr_sel;
  logic [31:0] hdr_dw;

  always_comb begin
    ev_legal    = err_valid && (err_space != SPACE_ILL) && (err_type != ERR_ILL);
    ev_idx      = status_idx(err_space, err_type);
    ev_unmasked = ev_legal && !pio_mask[ev_idx];
    set_vec     = ev_legal ? (32'd1 << ev_idx) : 32'd0;
    clr_vec     = (write_enable && (reg_addr == ADDR_STATUS)) ? write_data : 32'd0;
    // Set is applied after clear so a coincident set wins
    status_d    = ((status_q & ~clr_vec) | set_vec) & STATUS_VALID;
  end

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    req_d    = req_q;
    log_load = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (ev_unmasked) begin
          log_load = 1'b1;
          ptr_d    = ev_idx;
          req_d    = 1'b1;
          state_d  = ST_TRIG;
        end
      end
      ST_TRIG: begin
        if (dpc_trig_ack) begin
          req_d   = 1'b0;
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        // Released only once software has actually cleared the logged status bit
        if (!status_q[ptr_q]) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        req_d   = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      status_q <= '0;
      ptr_q    <= '0;
      req_q    <= 1'b0;
      state_q  <= ST_IDLE;
    end else begin
      status_q <= status_d;
      ptr_q    <= ptr_d;
      req_q    <= req_d;
      state_q  <= state_d;
    end
  end

  // Addresses 2..5 map to DW0..DW3 via a 2-bit offset of -2 (equivalently +2)
  assign hdr_sel = reg_addr[1:0] + 2'd2;

  rp_pio_hdr_log #(
    .N_DW  (HDR_DW),
    .SEL_W (2)
  ) u_hdr_log (
    .clk    (clk),
    .rst    (rst),
    .load   (log_load),
    .hdr_in (err_hdr),
    .dw_sel (hdr_sel),
    .dw_out (hdr_dw)
  );

  always_comb begin
    read_data = 32'd0;
    case (reg_addr)
      ADDR_STATUS: read_data = status_q;
      ADDR_PTR:    read_data = {27'd0, ptr_q};
      ADDR_HDR0, ADDR_HDR1, ADDR_HDR2, ADDR_HDR3: read_data = hdr_dw;
      default:     read_data = 32'd0;
    endcase
  end

  assign dpc_trig_req = req_q;

endmodule

// File: tb/tb_rp_pio_status_logger.sv
// Directed, table-driven bench for rp_pio_status_logger with hand-computed expectations.
module tb_rp_pio_status_logger;

  logic         clk;
  logic         rst;
  logic         err_valid;
  logic [1:0]   err_space;
  logic [1:0]   err_type;
  logic [127:0] err_hdr;
  logic [31:0]  pio_mask;
  logic [2:0]   reg_addr;
  logic         write_enable;
  logic [31:0]  write_data;
  logic [31:0]  read_data;
  logic         dpc_trig_req;
  logic         dpc_trig_ack;

  int n_cmp = 0;
  int n_mis = 0;

  rp_pio_status_logger dut (
    .clk          (clk),
    .rst          (rst),
    .err_valid    (err_valid),
    .err_space    (err_space),
    .err_type     (err_type),
    .err_hdr      (err_hdr),
    .pio_mask     (pio_mask),
    .reg_addr     (reg_addr),
    .write_enable (write_enable),
    .write_data   (write_data),
    .read_data    (read_data),
    .dpc_trig_req (dpc_trig_req),
    .dpc_trig_ack (dpc_trig_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [127:0] H1 = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
  localparam logic [127:0] H2 = 128'hAAAA_BBBB_CCCC_DDDD_EEEE_FFFF_0123_4567;

  typedef struct {
    logic         rst;
    logic         ev;
    logic [1:0]   sp;
    logic [1:0]   ty;
    logic [127:0] hdr;
    logic [31:0]  mask;
    logic         we;
    logic [2:0]   waddr;
    logic [31:0]  wdata;
    logic         ack;
    logic [31:0]  exp_status;
    logic [31:0]  exp_ptr;
    logic [31:0]  exp_dw0;
    logic         exp_req;
  } vec_t;

  localparam int NV = 23;
  vec_t vec [NV];

  function automatic vec_t mk(logic r, logic ev, logic [1:0] sp, logic [1:0] ty, logic [127:0] hdr,
                              logic [31:0] mask, logic we, logic [2:0] wa, logic [31:0] wd, logic ack,
                              logic [31:0] es, logic [31:0] ep, logic [31:0] ed, logic eq);
    vec_t v;
    v.rst = r; v.ev = ev; v.sp = sp; v.ty = ty; v.hdr = hdr; v.mask = mask;
    v.we = we; v.waddr = wa; v.wdata = wd; v.ack = ack;
    v.exp_status = es; v.exp_ptr = ep; v.exp_dw0 = ed; v.exp_req = eq;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    rst          = 1'b0;
    err_valid    = 1'b0;
    err_space    = 2'd0;
    err_type     = 2'd0;
    err_hdr      = '0;
    write_enable = 1'b0;
    write_data   = '0;
    dpc_trig_ack = 1'b0;
  endtask

  task automatic read_reg(input logic [2:0] a, output logic [31:0] d);
    reg_addr = a;
    #1;
    d = read_data;
  endtask

  initial begin
    logic [31:0] rd;
    //             rst ev sp ty hdr mask          we wa wdata          ack  status         ptr  dw0            req
    vec[0]  = mk(1, 0, 0, 0, '0, 32'h0,        0, 0, 32'h0,         0,   32'h0000_0000, 0,   32'h0,         0);
    vec[1]  = mk(0, 1, 2, 2, H1, 32'h0,        0, 0, 32'h0,         0,   32'h0004_0000, 18,  32'h7777_8888, 1);
    vec[2]  = mk(0, 0, 0, 0, '0, 32'h0,        0, 0, 32'h0,         0,   32'h0004_0000, 18,  32'h7777_8888, 1);
    vec[3]  = mk(0, 0, 0, 0, '0, 32'h0,        0, 0, 32'h0,         1,   32'h0004_0000, 18,  32'h7777_8888, 0);
    vec[4]  = mk(0, 1, 1, 1, H2, 32'h0,        0, 0, 32'h0,         0,   32'h0004_0200, 18,  32'h7777_8888, 0);
    vec[5]  = mk(0, 0, 0, 0, '0, 32'h0,        1, 0, 32'h0004_0000, 0,   32'h0000_0200, 18,  32'h7777_8888, 0);
    vec[6]  = mk(0, 0, 0, 0, '0, 32'h0,        0, 0, 32'h0,         0,   32'h0000_0200, 18,  32'h7777_8888, 0);
    vec[7]  = mk(0, 1, 0, 0, H2, 32'h1,        0, 0, 32'h0,         0,   32'h0000_0201, 18,  32'h7777_8888, 0);
    vec[8]  = mk(0, 0, 0, 0, '0, 32'h1,        0, 0, 32'h0,         1,   32'h0000_0201, 18,  32'h7777_8888, 0);
    vec[9]  = mk(0, 1, 0, 2, H2, 32'hFFFF_FFFF,0, 0, 32'h0,         0,   32'h0000_0205, 18,  32'h7777_8888, 0);
    vec[10] = mk(0, 1, 0, 2, H2, 32'hFFFF_FFFF,1, 0, 32'h0000_0005, 0,   32'h0000_0204, 18,  32'h7777_8888, 0);
    vec[11] = mk(0, 1, 3, 0, H2, 32'h0,        0, 0, 32'h0,         0,   32'h0000_0204, 18,  32'h7777_8888, 0);
    vec[12] = mk(0, 1, 0, 3, H2, 32'h0,        0, 0, 32'h0,         0,   32'h0000_0204, 18,  32'h7777_8888, 0);
    vec[13] = mk(0, 1, 0, 1, H2, 32'h0,        0, 0, 32'h0,         0,   32'h0000_0206, 1,   32'h0123_4567, 1);
    vec[14] = mk(1, 0, 0, 0, '0, 32'h0,        0, 0, 32'h0,         0,   32'h0000_0000, 0,   32'h0,         0);
    vec[15] = mk(0, 1, 2, 0, H1, 32'h0,        0, 0, 32'h0,         0,   32'h0001_0000, 16,  32'h7777_8888, 1);
    vec[16] = mk(0, 0, 0, 0, '0, 32'h0,        1, 1, 32'hFFFF_FFFF, 0,   32'h0001_0000, 16,  32'h7777_8888, 1);
    vec[17] = mk(0, 0, 0, 0, '0, 32'h0,        0, 0, 32'h0,         1,   32'h0001_0000, 16,  32'h7777_8888, 0);
    vec[18] = mk(0, 1, 2, 0, H2, 32'h0,        1, 0, 32'h0001_0000, 0,   32'h0001_0000, 16,  32'h7777_8888, 0);
    vec[19] = mk(0, 1, 0, 1, H2, 32'h0,        0, 0, 32'h0,         0,   32'h0001_0002, 16,  32'h7777_8888, 0);
    vec[20] = mk(0, 0, 0, 0, '0, 32'h0,        1, 0, 32'h0001_0000, 0,   32'h0000_0002, 16,  32'h7777_8888, 0);
    vec[21] = mk(0, 0, 0, 0, '0, 32'h0,        0, 0, 32'h0,         0,   32'h0000_0002, 16,  32'h7777_8888, 0);
    vec[22] = mk(0, 1, 1, 0, H2, 32'h0,        0, 0, 32'h0,         0,   32'h0000_0102, 8,   32'h0123_4567, 1);

    idle_inputs();
    rst      = 1'b1;
    pio_mask = '0;
    reg_addr = '0;

    for (int i = 0; i < NV; i++) begin
      rst          = vec[i].rst;
      err_valid    = vec[i].ev;
      err_space    = vec[i].sp;
      err_type     = vec[i].ty;
      err_hdr      = vec[i].hdr;
      pio_mask     = vec[i].mask;
      write_enable = vec[i].we;
      reg_addr     = vec[i].waddr;
      write_data   = vec[i].wdata;
      dpc_trig_ack = vec[i].ack;
      @(posedge clk);
      #1;
      idle_inputs();
      read_reg(3'd0, rd);
      check($sformatf("v%0d status", i), rd, vec[i].exp_status);
      read_reg(3'd1, rd);
      check($sformatf("v%0d first_ptr", i), rd, vec[i].exp_ptr);
      read_reg(3'd2, rd);
      check($sformatf("v%0d hdr_dw0", i), rd, vec[i].exp_dw0);
      check($sformatf("v%0d dpc_trig_req", i), {31'd0, dpc_trig_req}, {31'd0, vec[i].exp_req});
      $display("vec %0d: rst=%0b ev=%0b sp=%0d ty=%0d we=%0b wd=%08h ack=%0b -> status=%08h req=%0b",
               i, vec[i].rst, vec[i].ev, vec[i].sp, vec[i].ty, vec[i].we, vec[i].wdata,
               vec[i].ack, vec[i].exp_status, dpc_trig_req);
    end

    // Remaining header DWs of the last capture (H2) and the unmapped addresses
    read_reg(3'd3, rd);
    check("hdr_dw1", rd, 32'hEEEE_FFFF);
    read_reg(3'd4, rd);
    check("hdr_dw2", rd, 32'hCCCC_DDDD);
    read_reg(3'd5, rd);
    check("hdr_dw3", rd, 32'hAAAA_BBBB);
    read_reg(3'd6, rd);
    check("addr6_zero", rd, 32'h0);
    read_reg(3'd7, rd);
    check("addr7_zero", rd, 32'h0);
    $display("hdr readback: dw1..dw3 and unmapped addresses checked");

    // Request must persist across several cycles without ack, then drop one cycle after ack
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      check($sformatf("req_hold_c%0d", c), {31'd0, dpc_trig_req}, 32'd1);
    end
    dpc_trig_ack = 1'b1;
    @(posedge clk);
    #1;
    dpc_trig_ack = 1'b0;
    check("req_drop_after_ack", {31'd0, dpc_trig_req}, 32'd0);
    read_reg(3'd1, rd);
    check("ptr_after_ack", rd, 32'd8);
    $display("ack sequence: req dropped, first_ptr=%0d", rd);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/rp_pio_status_logger.md
Name: rp_pio_status_logger

Overview:
- Hardware-event side of the Root Port PIO error registers: converts PIO completion failures (UR, CA, CTO on Cfg/IO/Mem requests) into RP PIO Status bits (RW1C).
- Applies the 32-bit RP PIO Mask value supplied by the mask register.
- Captures the TLP header of the first unmasked error and requests DPC triggering.
- Sits between the PIO completion tracker (event source) and the DPC controller / config-space read mux.

Parameters:
- HDR_DW, 4, TLP header log depth in DWs; fixed at 4.
- ADDR_W, 3, register select width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- err_valid  in  1  one-cycle PIO error event strobe
- err_space  in  2  0 = Cfg, 1 = IO, 2 = Mem, 3 = illegal (event dropped)
- err_type  in  2  0 = UR cpl, 1 = CA cpl, 2 = CTO, 3 = illegal (event dropped)
- err_hdr  in  128  header of the failing request; DW0 in [31:0]
- pio_mask  in  32  RP PIO Mask register value, same bit layout as status
- reg_addr  in  3  0 = status, 1 = first-error pointer, 2..5 = header log DW0..DW3
- write_enable  in  1  config write strobe
- write_data  in  32  config write data
- read_data  out  32  combinational read of the register selected by reg_addr
- dpc_trig_req  out  1  DPC trigger request, level
- dpc_trig_ack  in  1  DPC controller acceptance

Behaviour:
- Status bit index = space*8 + type.
  - Cfg uses bits 0..2, IO uses 8..10, Mem uses 16..18.
  - All other status bits read 0 (RsvdZ).
- Reset (rst=1 at a clk edge):
  - status = 0, first_ptr = 0, hdr log = 0.
  - FSM enters IDLE; dpc_trig_req = 0.
- Event handling:
  - On err_valid with legal space/type, the status bit is set on the next clk edge, whether or not it is masked.
  - An event is "unmasked" when the corresponding pio_mask bit is 0.
- Status clear:
  - A write with reg_addr = 0 clears each status bit written with 1 (RW1C).
  - Writes to any other address are ignored.
  - If a set and a clear hit the same bit in the same cycle, the set wins: the bit remains 1.
- FSM states:
  - IDLE:
    - An unmasked event captures err_hdr into hdr log DW0..3 and loads first_ptr = bit index.
    - Next state is TRIG; dpc_trig_req = 1 from the next cycle.
  - TRIG:
    - dpc_trig_req is held at 1 until a cycle with dpc_trig_ack = 1, then the FSM moves to HOLD and dpc_trig_req = 0 on the next cycle.
    - An ack in IDLE or HOLD is ignored.
  - HOLD:
    - The log is locked; later events only set status bits.
    - Returns to IDLE on the cycle after the status bit indexed by first_ptr reads 0, i.e. after software has cleared it.
    - If the clear coincides with a re-set of that bit, the bit stays 1 and the FSM stays in HOLD.
  - Log lock in TRIG and HOLD: the header log and first_ptr do not change.
- Simultaneous events:
  - Only one event per cycle is possible by construction.
  - An unmasked event in the same cycle as a write clearing the first_ptr bit in HOLD is not logged. It sets status only.
- Reads:
  - read_data is combinational and has zero latency.
  - first_ptr reads as {27'b0, ptr[4:0]}.
  - Unmapped addresses (6, 7) read 0.
- Mask changes: these affect only future events and never the existing status bits.
- Reset during TRIG: dpc_trig_req drops on the reset edge and no ack is needed.

Decomposition:
- Package rp_pio_pkg holds:
  - enums pio_space_e and pio_err_e;
  - the status bit-index function and status valid-bit constant 32'h0007_0707;
  - the register address constants;
  - the FSM state enum.
- Sub-module rp_pio_hdr_log: a 4x32 capture register with a load strobe and a DW read mux. It is natural and reusable for the TLP prefix log.

Test Plan:
- Mem CTO event with mask = 0, hdr = 128'h1111_2222_3333_4444_5555_6666_7777_8888.
  - Expected: status = 32'h0004_0000, first_ptr = 18, DW0 = 32'h7777_8888.
  - dpc_trig_req rises the next cycle and drops the cycle after ack.
- Cfg UR event with mask = 32'h0000_0001.
  - Expected: status = 32'h0000_0001, no log capture, dpc_trig_req stays 0.
- In HOLD, an IO CA event.
  - Expected: status gains bit 9; hdr log and first_ptr are unchanged.
  - Then write 32'h0004_0000 to addr 0: bit 18 clears and the FSM returns to IDLE.
- Same cycle: write 1 to bit 2 and a Cfg CTO event.
  - Expected: bit 2 remains 1.
- Illegal space = 3 or type = 3.
  - Expected: no status change.
  - Read addr 6 returns 0.
- Assert rst while in TRIG.
  - Expected: all registers are 0 and dpc_trig_req = 0 the next cycle.
  - A subsequent unmasked event logs normally.
